piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/serializer_pkg.sv | 19 +
 rtl/ser_hold_buf.sv | 63 ++++++
 rtl/piso_serializer.sv | 128 ++++++++++++
 tb/tb_piso_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encoding and the default parallel word width.
package serializer_pkg;

  // Default parallel word width; any width >= 2 is supported.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Serializer control states: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Index of the bit driven onto the serial line for a given order.
  function automatic int unsigned out_bit_index(input logic msb_first, input int unsigned width);
    return msb_first ? (width - 1) : 0;
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-word holding register in front of the serializer. Accepts a word
// plus its bit order on a valid/ready handshake and hands it to the shifter
// when the serializer pops it. Ready is purely the inverse of the full flag,
// so it never depends combinationally on load_valid.
module ser_hold_buf
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             msb_first,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             pop,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_msb
);

  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_msb_q,  hold_msb_d;
  logic             accept;

  // A word is taken only while the register is empty. The shifter pops only
  // when the register is full, so a pop and an accept can never share an edge.
  assign accept = load_valid && !hold_full_q;

  // Next-state for the holding register: pop empties it, accept fills it.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_msb_d  = hold_msb_q;
    if (pop) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = par_data;
      hold_msb_d  = msb_first;
    end
  end

  // Holding register state; reset discards any held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_msb_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_msb_q  <= hold_msb_d;
    end
  end

  assign load_ready = !hold_full_q;
  assign hold_full  = hold_full_q;
  assign hold_data  = hold_data_q;
  assign hold_msb   = hold_msb_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer. A word handed over through the
// holding buffer is loaded into a shift register and sent one bit per
// cycle of shift_en, MSB or LSB first as captured with the word. A word
// held in the buffer is chained onto the end of the current one with no
// idle gap. done pulses in the cycle after the last bit is consumed.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             order_q, order_d;
  logic             done_q, done_d;

  logic             pop;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_msb;
  logic             in_shift;

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk        (clk),
    .reset_n    (reset_n),
    .par_data   (par_data),
    .msb_first  (msb_first),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pop        (pop),
    .hold_full  (hold_full),
    .hold_data  (hold_data),
    .hold_msb   (hold_msb)
  );

  // Next-state logic: load from the holding register, shift on shift_en,
  // and on the last bit either chain the held word or drop back to IDLE.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    order_d   = order_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          shreg_d   = hold_data;
          order_d   = hold_msb;
          bit_cnt_d = '0;
          pop       = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (bit_cnt_q == LAST_BIT) begin
            done_d = 1'b1;
            if (hold_full) begin
              shreg_d   = hold_data;
              order_d   = hold_msb;
              bit_cnt_d = '0;
              pop       = 1'b1;
            end else begin
              shreg_d   = '0;
              bit_cnt_d = '0;
              state_d   = IDLE;
            end
          end else begin
            // Shift toward whichever end feeds serial_out.
            if (order_q) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shifter, counter and done registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      order_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      order_q   <= order_d;
      done_q    <= done_d;
    end
  end

  // Serial outputs are gated by SHIFT so IDLE (and reset) always shows zeros.
  assign in_shift    = (state_q == SHIFT);
  assign ser_valid   = in_shift;
  assign serial_out  = in_shift && shreg_q[out_bit_index(order_q, WIDTH)];
  assign frame_start = in_shift && (bit_cnt_q == '0);
  assign done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4). Accepted words push their
// expected bit stream into a scoreboard; a negedge monitor pops and compares
// each bit as it is consumed and checks frame_start, done and hold lengths.
module tb_piso_serializer;

  logic       clk;
  logic       reset_n;
  logic [3:0] par_data;
  logic       load_valid;
  logic       load_ready;
  logic       msb_first;
  logic       shift_en;
  logic       serial_out;
  logic       ser_valid;
  logic       frame_start;
  logic       done;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   shift_period = 1;
  int   hold_cnt = 0;
  int   bits_consumed = 0;
  int   done_pulses = 0;
  logic done_exp = 1'b0;
  bit   saw_not_ready = 1'b0;

  piso_serializer #(
    .WIDTH(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .par_data    (par_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .msb_first   (msb_first),
    .shift_en    (shift_en),
    .serial_out  (serial_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    shift_en = (shift_period <= 1) ? 1'b1 : ((cyc % shift_period) == 0);
  endtask

  // Offer a word until accepted, then push its expected bits.
  task automatic send_word(input logic [3:0] d, input logic m, input bit keep_valid);
    bit   ok;
    logic r;
    exp_t e;
    ok = 1'b0;
    load_valid = 1'b1;
    par_data   = d;
    msb_first  = m;
    for (int w = 0; w < 40 && !ok; w++) begin
      r = load_ready;
      if (!r) saw_not_ready = 1'b1;
      tick();
      if (r) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          e.b     = m ? d[3-i] : d[i];
          e.first = (i == 0);
          e.last  = (i == 3);
          sb.push_back(e);
        end
        $display("accepted word=%h msb_first=%0d at cycle %0d", d, m, cyc);
      end
    end
    check("accept_timeout", ok, 1);
    if (!keep_valid) begin
      load_valid = 1'b0;
      msb_first  = ~m;   // must not disturb the captured order
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && (sb.size() != 0 || ser_valid); k++) tick();
    check("drain", (sb.size() == 0) && !ser_valid, 1);
    tick();
    tick();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t item;
    logic pend;
    pend = 1'b0;
    if (!reset_n) begin
      sb.delete();
      done_exp = 1'b0;
      hold_cnt = 0;
      check("rst_done", done, 0);
      check("rst_valid", ser_valid, 0);
    end else begin
      check("done", done, done_exp);
      if (done) done_pulses++;
      if (ser_valid) begin
        if (sb.size() == 0) begin
          check("spurious_bit", ser_valid, 0);
        end else begin
          item = sb[0];
          hold_cnt++;
          check("serial_out", serial_out, item.b);
          check("frame_start", frame_start, item.first);
          if (shift_en) begin
            if (!item.first) check("hold_len", hold_cnt, shift_period);
            void'(sb.pop_front());
            hold_cnt = 0;
            bits_consumed++;
            pend = item.last;
          end
        end
      end else begin
        check("idle_serial", serial_out, 0);
        check("idle_frame", frame_start, 0);
      end
      done_exp = pend;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int dp;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    par_data   = '0;
    msb_first  = 1'b0;
    shift_en   = 1'b1;
    #2;
    check("reset_serial", serial_out, 0);
    check("reset_valid", ser_valid, 0);
    check("reset_frame", frame_start, 0);
    check("reset_done", done, 0);
    check("reset_ready", load_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // MSB first 1011: word offered in cycle n, first bit visible in cycle n+2.
    send_word(4'b1011, 1'b1, 1'b0);
    check("lat_not_yet", ser_valid, 0);
    tick();
    check("lat_first_valid", ser_valid, 1);
    check("lat_first_frame", frame_start, 1);
    check("lat_first_bit", serial_out, 1);
    wait_drain(40);

    // LSB first 1011 -> 1,1,0,1
    send_word(4'b1011, 1'b0, 1'b0);
    wait_drain(40);

    // Back-to-back A then 5, second offered while first is shifting.
    dp = done_pulses;
    send_word(4'hA, 1'b1, 1'b0);
    send_word(4'h5, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      check("contiguous_valid", ser_valid, 1);
      tick();
    end
    wait_drain(40);
    check("two_done_pulses", done_pulses - dp, 2);

    // Bit-rate enable every third cycle: each bit held 3 cycles.
    shift_period = 3;
    send_word(4'b1011, 1'b1, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0);
    wait_drain(80);
    shift_period = 1;
    tick();

    // Reset mid-word with a second word held.
    base = bits_consumed;
    dp   = done_pulses;
    send_word(4'hC, 1'b1, 1'b0);
    send_word(4'h3, 1'b1, 1'b0);
    for (int k = 0; k < 20 && (bits_consumed - base) < 2; k++) tick();
    check("two_bits_out", bits_consumed - base, 2);
    check("held_not_ready", load_ready, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_serial", serial_out, 0);
    check("midrst_valid", ser_valid, 0);
    check("midrst_frame", frame_start, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", load_ready, 1);
    tick();
    reset_n = 1'b1;
    check("postrst_ready", load_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("postrst_idle", ser_valid, 0);
    end
    check("no_done_after_rst", done_pulses - dp, 0);

    // load_valid held across words 1,2,3.
    saw_not_ready = 1'b0;
    send_word(4'h1, 1'b1, 1'b1);
    send_word(4'h2, 1'b1, 1'b1);
    send_word(4'h3, 1'b1, 1'b0);
    check("ready_dropped", saw_not_ready, 1);
    wait_drain(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
